// File: rtl/divu_seq_pkg.sv
// Shared definitions for the sequential unsigned divider: ALU Signal opcodes
// and the divider FSM state encoding.
package divu_seq_pkg;

  localparam logic [5:0] OP_SRL   = 6'd2;
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd18;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_DIVU  = 6'd27;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_SLT   = 6'd42;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divu_seq_div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when it fits.
module divu_seq_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial;
  logic             ge;

  assign rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign trial  = {1'b0, rem_sh} - {1'b0, divisor};
  // A set bit shifted out of rem means the true shifted value is >= 2^WIDTH,
  // which always exceeds the divisor even if the 33-bit trial shows a borrow.
  assign ge      = rem[WIDTH-1] | ~trial[WIDTH];
  assign rem_nxt = ge ? trial[WIDTH-1:0] : rem_sh;
  assign quo_nxt = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/divu_seq.sv
// Multi-cycle unsigned divider for DIVU: one quotient bit per clock,
// result {remainder, quotient} delivered with a one-cycle done pulse.
module divu_seq
  import divu_seq_pkg::*;
#(
  parameter int         WIDTH = 32,
  parameter logic [5:0] DIVU  = OP_DIVU
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [5:0]         Signal,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               divByZero,
  output logic [2*WIDTH-1:0] dataOut
);

  div_state_t       state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             accept;

  divu_seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign accept = start && (Signal == DIVU);
  assign busy   = (state == S_BUSY);
  assign done   = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      divByZero <= 1'b0;
      dataOut   <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          divisor <= dataB;
          quo     <= dataA;
          rem     <= '0;
          cnt     <= '0;
          if (dataB == '0) begin
            // Zero divisor skips iteration: all-ones quotient, dividend as remainder.
            state     <= S_DONE;
            divByZero <= 1'b1;
            dataOut   <= {dataA, {WIDTH{1'b1}}};
          end else begin
            state     <= S_BUSY;
            divByZero <= 1'b0;
          end
        end
        S_BUSY: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state   <= S_DONE;
            dataOut <= {rem_nxt, quo_nxt};
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divu_seq.sv
// Directed bench for divu_seq: latency, results, divide-by-zero, ignored
// requests, asynchronous abort and back-to-back operation.
module tb_divu_seq;
  import divu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [5:0]  Signal;
  logic        start;
  logic        busy, done, divByZero;
  logic [63:0] dataOut;

  int vectors = 0;
  int errors  = 0;

  divu_seq dut (
    .clk       (clk),
    .reset     (reset),
    .dataA     (dataA),
    .dataB     (dataB),
    .Signal    (Signal),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .dataOut   (dataOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op, then advances until done (or a 100-cycle bound).
  // lat is the cycle number (accept edge = cycle 0) in which done is seen.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cnt, output bit hold_ok);
    logic [63:0] prev;
    dataA = a; dataB = b; Signal = OP_DIVU; start = 1'b1;
    prev = dataOut;
    tick();
    start = 1'b0;
    lat = 1; busy_cnt = 0; hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (dataOut !== prev) hold_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; Signal = 6'd0; dataA = '0; dataB = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (divByZero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", divByZero); end
    vectors++; if (dataOut !== 64'd0) begin errors++; $display("FAIL reset_dataOut got=%h exp=0", dataOut); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, bc; bit hold;
    do_op(32'd100, 32'd7, lat, bc, hold);
    vectors++; if (lat !== 33) begin errors++; $display("FAIL basic_latency got=%0d exp=33", lat); end
    vectors++; if (bc !== 32) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=32", bc); end
    vectors++; if (!hold) begin errors++; $display("FAIL basic_dataOut_midbusy got=changed exp=held"); end
    vectors++; if (dataOut !== {32'd2, 32'd14}) begin errors++; $display("FAIL basic_result got=%h exp=%h", dataOut, {32'd2, 32'd14}); end
    vectors++; if (divByZero !== 1'b0) begin errors++; $display("FAIL basic_dbz got=%b exp=0", divByZero); end
    tick();
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=done%b busy%b exp=00", done, busy); end
  endtask

  task automatic test_extremes();
    int lat, bc; bit hold;
    do_op(32'hFFFFFFFF, 32'd1, lat, bc, hold);
    vectors++; if (dataOut !== {32'd0, 32'hFFFFFFFF}) begin errors++; $display("FAIL ext_max_div1 got=%h exp=%h", dataOut, {32'd0, 32'hFFFFFFFF}); end
    vectors++; if (lat !== 33) begin errors++; $display("FAIL ext_max_latency got=%0d exp=33", lat); end
    repeat (4) tick();
    vectors++; if (dataOut !== {32'd0, 32'hFFFFFFFF}) begin errors++; $display("FAIL ext_hold got=%h exp=%h", dataOut, {32'd0, 32'hFFFFFFFF}); end
    tick();
    do_op(32'd3, 32'd10, lat, bc, hold);
    vectors++; if (dataOut !== {32'd3, 32'd0}) begin errors++; $display("FAIL ext_small got=%h exp=%h", dataOut, {32'd3, 32'd0}); end
    tick();
    do_op(32'hFFFFFFFF, 32'h80000001, lat, bc, hold);
    vectors++; if (dataOut !== {32'h7FFFFFFE, 32'd1}) begin errors++; $display("FAIL ext_big_divisor got=%h exp=%h", dataOut, {32'h7FFFFFFE, 32'd1}); end
    tick();
    do_op(32'hFFFFFFFE, 32'hFFFFFFFF, lat, bc, hold);
    vectors++; if (dataOut !== {32'hFFFFFFFE, 32'd0}) begin errors++; $display("FAIL ext_div_gt_dvd got=%h exp=%h", dataOut, {32'hFFFFFFFE, 32'd0}); end
    tick();
  endtask

  task automatic test_div_zero();
    int lat, bc; bit hold;
    do_op(32'd5, 32'd0, lat, bc, hold);
    vectors++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got=%0d exp=1", lat); end
    vectors++; if (dataOut !== {32'd5, 32'hFFFFFFFF}) begin errors++; $display("FAIL dz_result got=%h exp=%h", dataOut, {32'd5, 32'hFFFFFFFF}); end
    vectors++; if (divByZero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", divByZero); end
    repeat (3) tick();
    vectors++; if (divByZero !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL dz_hold got=dbz%b done%b exp=10", divByZero, done); end
    do_op(32'd8, 32'd2, lat, bc, hold);
    vectors++; if (divByZero !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b exp=0", divByZero); end
    vectors++; if (dataOut !== {32'd0, 32'd4}) begin errors++; $display("FAIL dz_next_result got=%h exp=%h", dataOut, {32'd0, 32'd4}); end
    tick();
  endtask

  task automatic test_ignored();
    int n; bit stray;
    dataA = 32'd9; dataB = 32'd3; Signal = OP_ADD; start = 1'b1;
    stray = 1'b0;
    repeat (3) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) stray = 1'b1;
    end
    start = 1'b0;
    vectors++; if (stray) begin errors++; $display("FAIL ign_wrong_signal got=activity exp=idle"); end
    vectors++; if (dataOut !== {32'd0, 32'd4}) begin errors++; $display("FAIL ign_dataOut got=%h exp=%h", dataOut, {32'd0, 32'd4}); end
    // start again with new operands in cycle 10 of a running op
    dataA = 32'd100; dataB = 32'd7; Signal = OP_DIVU; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      if (n == 10) begin dataA = 32'd1; dataB = 32'd1; start = 1'b1; end
      else start = 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    vectors++; if (n !== 33) begin errors++; $display("FAIL ign_midop_latency got=%0d exp=33", n); end
    vectors++; if (dataOut !== {32'd2, 32'd14}) begin errors++; $display("FAIL ign_midop_result got=%h exp=%h", dataOut, {32'd2, 32'd14}); end
    tick();
  endtask

  task automatic test_reset_abort();
    int lat, bc, pulses; bit hold;
    dataA = 32'd100; dataB = 32'd7; Signal = OP_DIVU; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    #2 reset = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    vectors++; if (dataOut !== 64'd0) begin errors++; $display("FAIL abort_dataOut got=%h exp=0", dataOut); end
    tick();
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    do_op(32'd81, 32'd9, lat, bc, hold);
    vectors++; if (dataOut !== {32'd0, 32'd9}) begin errors++; $display("FAIL abort_fresh_result got=%h exp=%h", dataOut, {32'd0, 32'd9}); end
    vectors++; if (lat !== 33) begin errors++; $display("FAIL abort_fresh_latency got=%0d exp=33", lat); end
    tick();
  endtask

  task automatic test_back_to_back();
    int cnt;
    int at [3];
    at[0] = 0; at[1] = 0; at[2] = 0;
    cnt = 0;
    dataA = 32'd1000; dataB = 32'd10; Signal = OP_DIVU; start = 1'b1;
    tick();
    for (int n = 1; n <= 101; n++) begin
      if (done === 1'b1) begin
        if (cnt < 3) at[cnt] = n;
        cnt++;
      end
      tick();
    end
    start = 1'b0;
    vectors++; if (cnt !== 3) begin errors++; $display("FAIL b2b_pulse_count got=%0d exp=3", cnt); end
    vectors++; if (at[0] !== 33) begin errors++; $display("FAIL b2b_first got=%0d exp=33", at[0]); end
    vectors++; if (at[1] !== 67) begin errors++; $display("FAIL b2b_second got=%0d exp=67", at[1]); end
    vectors++; if (at[2] !== 101) begin errors++; $display("FAIL b2b_third got=%0d exp=101", at[2]); end
    vectors++; if (dataOut !== {32'd0, 32'd100}) begin errors++; $display("FAIL b2b_result got=%h exp=%h", dataOut, {32'd0, 32'd100}); end
    tick();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
